// File: rtl/us_ranging_sequencer.sv
// Ultrasonic ranging sequencer: piezo burst, receiver blanking, echo listen window and
// time-of-flight capture, started single-shot or periodically over an Avalon-MM slave.
module us_ranging_sequencer #(
  parameter logic [31:0] BURST_DEFAULT   = 32'd5000,
  parameter logic [31:0] BLANK_DEFAULT   = 32'd2000,
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd500000,
  parameter logic [31:0] PERIOD_DEFAULT  = 32'd2500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] time_cnt,
  input  logic        echo_detect,
  input  logic [15:0] avalon_slave_address,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  input  logic        avalon_slave_read,
  output logic [31:0] avalon_slave_readdata,
  output logic        avalon_slave_waitrequest,
  output logic        piezo_enable,
  output logic        detector_arm,
  output logic        cycle_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BURST  = 3'd1,
    BLANK  = 3'd2,
    LISTEN = 3'd3,
    DONE   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] burst_len, blank_len, timeout_len, period_len;
  logic [31:0] burst_q, blank_q, timeout_q, period_q;
  logic [31:0] tx_time, echo_time, tof, seq_count;
  logic [31:0] cnt, elapsed;
  logic        continuous, valid, timeout, read_phase;
  logic [7:0]  idx;
  logic        wr_en, ctrl_wr, start, abort, period_up;
  logic [31:0] rdata;
  logic        unused_addr;

  assign idx         = avalon_slave_address[15:8];
  assign unused_addr = ^avalon_slave_address[7:0];

  // read_phase marks the second cycle of a read; the first cycle always stalls
  assign avalon_slave_waitrequest = avalon_slave_read && !read_phase;
  assign wr_en   = avalon_slave_write && !avalon_slave_waitrequest;
  assign ctrl_wr = wr_en && (idx == 8'h00);
  assign start   = ctrl_wr && avalon_slave_writedata[0];
  assign abort   = ctrl_wr && avalon_slave_writedata[2];

  // elapsed counts cycles since the first BURST cycle; true when the next cycle hits PERIOD
  assign period_up = ({1'b0, elapsed} + 33'd1) >= {1'b0, period_q};

  // outputs are decoded straight from the state register, so they change only on edges
  assign piezo_enable = (state == BURST);
  assign detector_arm = (state == LISTEN);
  assign cycle_done   = (state == DONE);
  assign busy         = (state != IDLE);

  always_comb begin
    rdata = 32'hDEADBEEF;
    case (idx)
      8'h00: rdata = {24'b0, busy, state, 2'b0, timeout, valid};
      8'h01: rdata = burst_len;
      8'h02: rdata = blank_len;
      8'h03: rdata = timeout_len;
      8'h04: rdata = period_len;
      8'h05: rdata = tx_time;
      8'h06: rdata = echo_time;
      8'h07: rdata = tof;
      8'h08: rdata = seq_count;
      default: rdata = 32'hDEADBEEF;
    endcase
  end

  assign avalon_slave_readdata = (avalon_slave_read && read_phase) ? rdata : 32'd0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      burst_len   <= BURST_DEFAULT;
      blank_len   <= BLANK_DEFAULT;
      timeout_len <= TIMEOUT_DEFAULT;
      period_len  <= PERIOD_DEFAULT;
      burst_q     <= BURST_DEFAULT;
      blank_q     <= BLANK_DEFAULT;
      timeout_q   <= TIMEOUT_DEFAULT;
      period_q    <= PERIOD_DEFAULT;
      tx_time     <= '0;
      echo_time   <= '0;
      tof         <= '0;
      seq_count   <= '0;
      cnt         <= '0;
      elapsed     <= '0;
      continuous  <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      read_phase  <= 1'b0;
    end else begin
      read_phase <= avalon_slave_read && !read_phase;
      if (elapsed != '1) elapsed <= elapsed + 32'd1;

      if (wr_en) begin
        case (idx)
          8'h00: continuous  <= avalon_slave_writedata[1];
          8'h01: burst_len   <= avalon_slave_writedata;
          8'h02: blank_len   <= avalon_slave_writedata;
          8'h03: timeout_len <= avalon_slave_writedata;
          8'h04: period_len  <= avalon_slave_writedata;
          default: ;
        endcase
      end

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            burst_q   <= burst_len;
            blank_q   <= blank_len;
            timeout_q <= timeout_len;
            period_q  <= period_len;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= 32'd1;
            elapsed   <= '0;
            state     <= BURST;
          end
          // cnt is 1 on the first cycle of each timed state, so a zero length still lasts one cycle
          BURST: begin
            if (cnt == 32'd1) tx_time <= time_cnt;
            if (cnt >= burst_q) begin
              cnt <= 32'd1;
              if (blank_q == '0) state <= LISTEN;
              else               state <= BLANK;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          BLANK: begin
            if (cnt >= blank_q) begin
              cnt   <= 32'd1;
              state <= LISTEN;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          LISTEN: begin
            if (echo_detect) begin
              echo_time <= time_cnt;
              tof       <= time_cnt - tx_time;
              valid     <= 1'b1;
              seq_count <= seq_count + 32'd1;
              state     <= DONE;
            end else if (cnt >= timeout_q) begin
              tof       <= 32'hFFFFFFFF;
              timeout   <= 1'b1;
              seq_count <= seq_count + 32'd1;
              state     <= DONE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          DONE, GAP: begin
            if (!continuous) begin
              state <= IDLE;
            end else if (period_up) begin
              burst_q   <= burst_len;
              blank_q   <= blank_len;
              timeout_q <= timeout_len;
              period_q  <= period_len;
              cnt       <= 32'd1;
              elapsed   <= '0;
              state     <= BURST;
            end else begin
              state <= GAP;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_us_ranging_sequencer.sv
// Randomized self-checking bench for us_ranging_sequencer; expected timing and results are
// computed from cycle arithmetic on the programmed lengths and the planned echo pattern.
module tb_us_ranging_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cyc   = '0;
  logic [31:0] tbase = '0;
  logic [31:0] time_cnt;
  logic        echo_detect = 1'b0;
  logic [15:0] address = '0;
  logic        write = 1'b0, read = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] readdata;
  logic        waitreq, piezo, arm, done, busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_seq  = '0;
  logic [31:0] exp_echo = '0;
  // echo plan: up to two high intervals, as offsets from the first BURST cycle
  logic [31:0] e_lo [2];
  logic [31:0] e_hi [2];

  us_ranging_sequencer #(
    .BURST_DEFAULT(32'd5000), .BLANK_DEFAULT(32'd2000),
    .TIMEOUT_DEFAULT(32'd500000), .PERIOD_DEFAULT(32'd2500000)
  ) dut (
    .clock(clock), .reset(reset), .time_cnt(time_cnt), .echo_detect(echo_detect),
    .avalon_slave_address(address), .avalon_slave_write(write),
    .avalon_slave_writedata(wdata), .avalon_slave_read(read),
    .avalon_slave_readdata(readdata), .avalon_slave_waitrequest(waitreq),
    .piezo_enable(piezo), .detector_arm(arm), .cycle_done(done), .busy(busy)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 32'd1;
  assign time_cnt = tbase + cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [31:0] d);
    address = {idx, 8'h00}; wdata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] idx, output logic [31:0] d);
    address = {idx, 8'h00}; read = 1'b1;
    #1;
    chk("waitreq_first", 32'(waitreq), 32'd1);
    tick();
    chk("waitreq_second", 32'(waitreq), 32'd0);
    d = readdata;
    read = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    logic [31:0] v;
    rd(idx, v);
    chk(tag, v, exp);
  endtask

  function automatic bit echo_at(input logic [31:0] off);
    return (off >= e_lo[0] && off <= e_hi[0]) || (off >= e_lo[1] && off <= e_hi[1]);
  endfunction

  task automatic no_echo();
    e_lo[0] = 32'd1; e_hi[0] = 32'd0; e_lo[1] = 32'd1; e_hi[1] = 32'd0;
  endtask

  // one single-shot measurement; txv is the time_cnt value wanted on the first BURST cycle
  task automatic run_shot(input string tag, input logic [31:0] b, input logic [31:0] l,
                          input logic [31:0] t, input logic [31:0] txv);
    logic [31:0] n, s, be, te, e, exp_done, exp_tof, done_cyc, pz;
    bit hit, seen;
    wr(8'h01, b); wr(8'h02, l); wr(8'h03, t);
    n = cyc;
    tbase = txv - (n + 32'd1);
    wr(8'h00, 32'd1);

    be = (b == 0) ? 32'd1 : b;
    te = (t == 0) ? 32'd1 : t;
    s  = n + 32'd1 + be + l;
    hit = 1'b0; e = '0;
    for (int unsigned c = s; c < s + te; c++)
      if (!hit && echo_at(c - (n + 32'd1))) begin hit = 1'b1; e = c; end
    exp_done = hit ? e + 32'd1 : s + te;
    exp_tof  = hit ? e - (n + 32'd1) : 32'hFFFFFFFF;
    if (hit) exp_echo = txv + (e - (n + 32'd1));
    exp_seq++;

    pz = '0; seen = 1'b0; done_cyc = '0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      echo_detect = echo_at(cyc - (n + 32'd1));
      if (piezo) pz++;
      if (done) begin seen = 1'b1; done_cyc = cyc; end
      else tick();
    end
    echo_detect = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_piezo_cycles"}, pz, be);
    chk({tag, "_done_cycle"}, done_cyc - n, exp_done - n);
    tick();
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    rd_chk({tag, "_tof"}, 8'h07, exp_tof);
    rd_chk({tag, "_seq"}, 8'h08, exp_seq);
    rd_chk({tag, "_ctrl"}, 8'h00, hit ? 32'd1 : 32'd2);
    rd_chk({tag, "_tx"}, 8'h05, txv);
    rd_chk({tag, "_echo"}, 8'h06, exp_echo);
  endtask

  initial begin
    logic [31:0] n;
    logic [31:0] edges [$];
    logic        prev;
    bit          seen;

    no_echo();
    repeat (3) tick();
    chk("rst_piezo", 32'(piezo), 0);
    chk("rst_arm", 32'(arm), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", readdata, 0);
    reset = 1'b1;
    tick();
    rd_chk("def_ctrl", 8'h00, 32'd0);
    rd_chk("def_burst", 8'h01, 32'd5000);
    rd_chk("def_blank", 8'h02, 32'd2000);
    rd_chk("def_timeout", 8'h03, 32'd500000);
    rd_chk("def_period", 8'h04, 32'd2500000);
    rd_chk("def_seq", 8'h08, 32'd0);
    rd_chk("unmapped_09", 8'h09, 32'hDEADBEEF);
    rd_chk("unmapped_ff", 8'hFF, 32'hDEADBEEF);
    wr(8'h07, 32'd123);
    rd_chk("ro_write_ignored", 8'h07, 32'd0);

    // abort and start in the same write: abort wins
    wr(8'h00, 32'd5);
    chk("abort_start_busy", 32'(busy), 0);
    chk("abort_start_piezo", 32'(piezo), 0);

    no_echo(); e_lo[0] = 32'd35; e_hi[0] = 32'd35;
    run_shot("single", 32'd10, 32'd5, 32'd100, 32'h0000_1000);
    no_echo();
    run_shot("timeout", 32'd10, 32'd5, 32'd100, 32'h0000_2000);
    no_echo(); e_lo[0] = 32'd10; e_hi[0] = 32'd14; e_lo[1] = 32'd114; e_hi[1] = 32'd114;
    run_shot("blank_prec", 32'd10, 32'd5, 32'd100, 32'h0000_3000);
    no_echo(); e_lo[0] = 32'd40; e_hi[0] = 32'd40;
    run_shot("wrap", 32'd10, 32'd5, 32'd100, 32'hFFFFFFF0);
    no_echo(); e_lo[0] = 32'd0; e_hi[0] = 32'd3;
    run_shot("zero_lens", 32'd0, 32'd0, 32'd0, 32'h0000_4000);

    for (int i = 0; i < 12; i++) begin
      no_echo();
      if ($urandom_range(0, 3) != 0) begin
        e_lo[0] = 32'($urandom_range(0, 60));
        e_hi[0] = e_lo[0] + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) != 0) begin
        e_lo[1] = 32'($urandom_range(0, 60));
        e_hi[1] = e_lo[1] + 32'($urandom_range(0, 2));
      end
      run_shot($sformatf("rand%0d", i), 32'($urandom_range(0, 12)), 32'($urandom_range(0, 8)),
               32'($urandom_range(0, 40)), $urandom);
    end

    // continuous mode: bursts start every PERIOD cycles, then clear continuous in GAP
    no_echo();
    wr(8'h01, 32'd10); wr(8'h02, 32'd5); wr(8'h03, 32'd50); wr(8'h04, 32'd200);
    n = cyc;
    wr(8'h00, 32'd3);
    prev = 1'b0;
    for (int k = 0; k < 650; k++) begin
      if (piezo && !prev) edges.push_back(cyc);
      prev = piezo;
      tick();
    end
    chk("cont_edges", 32'(edges.size()), 32'd4);
    for (int k = 0; k < edges.size() && k < 4; k++)
      chk($sformatf("cont_edge%0d", k), edges[k] - n, 32'd1 + 32'd200 * 32'(k));
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("cont_done_seen", 32'(seen), 32'd1);
    tick();
    wr(8'h00, 32'd0);
    tick();
    chk("cont_stop_busy", 32'(busy), 0);
    exp_seq = exp_seq + 32'd4;
    rd_chk("cont_seq", 8'h08, exp_seq);

    // abort during BURST
    wr(8'h01, 32'd50); wr(8'h02, 32'd5); wr(8'h03, 32'd100);
    wr(8'h00, 32'd1);
    repeat (3) tick();
    chk("abort_pre_piezo", 32'(piezo), 1);
    wr(8'h00, 32'd4);
    chk("abort_piezo", 32'(piezo), 0);
    chk("abort_busy", 32'(busy), 0);
    rd_chk("abort_seq", 8'h08, exp_seq);
    rd_chk("abort_ctrl", 8'h00, 32'd0);

    // reset while listening
    wr(8'h01, 32'd10); wr(8'h02, 32'd5); wr(8'h03, 32'd1000);
    wr(8'h00, 32'd1);
    repeat (20) tick();
    chk("listen_arm", 32'(arm), 1);
    reset = 1'b0;
    tick();
    chk("rst2_arm", 32'(arm), 0);
    chk("rst2_piezo", 32'(piezo), 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_done", 32'(done), 0);
    reset = 1'b1;
    tick();
    rd_chk("rst2_burst", 8'h01, 32'd5000);
    rd_chk("rst2_timeout", 8'h03, 32'd500000);
    rd_chk("rst2_seq", 8'h08, 32'd0);
    rd_chk("rst2_tof", 8'h07, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
